conway_serial_sequencer: RTL and testbench

Host-side controller that drives the 8x8 serial Conway core through one complete job.
- Shifts a 64-bit seed into the core in load mode.
- Runs the core for a programmable number of generations in run mode.
- Shifts the resulting grid back out in output mode and presents it as a parallel word with a done pulse.
- Sits directly upstream/downstream of the core: its DATA_OUT/MODE feed the core's DATA_IN/MODE, and the core's DATA_OUT returns on DATA_IN.

---
 rtl/conway_pkg.sv | 32 +++
 rtl/conway_serial_sequencer_if.sv | 27 ++
 rtl/seq_shift_reg.sv | 32 +++
 rtl/conway_serial_sequencer.sv | 121 ++++++++++++
 tb/tb_conway_serial_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/conway_pkg.sv
// Shared types and constants for the Conway serial sequencer.
//   seq_state_t : job FSM states
//   MODE_*      : 2-bit mode codes understood by the serial Conway core
//   mode_of()   : state -> core mode decode
package conway_pkg;

  localparam int DATA_SIZE_DEF = 64;
  localparam int GEN_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  localparam logic [1:0] MODE_LOAD   = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_OUTPUT = 2'b10;
  localparam logic [1:0] MODE_STOP   = 2'b11;

  function automatic logic [1:0] mode_of(input seq_state_t s);
    case (s)
      LOAD:    return MODE_LOAD;
      RUN:     return MODE_RUN;
      READ:    return MODE_OUTPUT;
      default: return MODE_STOP;
    endcase
  endfunction

endpackage

// File: rtl/conway_serial_sequencer_if.sv
// Host/core-facing bundle of the Conway serial sequencer.
//   master : job requester + core side (drives START/GRID_LOAD/GEN_COUNT/DATA_IN)
//   slave  : the sequencer (drives DATA_OUT/MODE/BUSY/DONE/GRID_RESULT)
interface conway_serial_sequencer_if #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
);
  logic                 START;
  logic [DATA_SIZE-1:0] GRID_LOAD;
  logic [GEN_WIDTH-1:0] GEN_COUNT;
  logic                 DATA_IN;
  logic                 DATA_OUT;
  logic [1:0]           MODE;
  logic                 BUSY;
  logic                 DONE;
  logic [DATA_SIZE-1:0] GRID_RESULT;

  modport master (
    output START, GRID_LOAD, GEN_COUNT, DATA_IN,
    input  DATA_OUT, MODE, BUSY, DONE, GRID_RESULT
  );

  modport slave (
    input  START, GRID_LOAD, GEN_COUNT, DATA_IN,
    output DATA_OUT, MODE, BUSY, DONE, GRID_RESULT
  );
endinterface

// File: rtl/seq_shift_reg.sv
// Parameterised left-shift register with parallel load.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : load i_load_val (wins over i_shift)
//   i_shift, i_sin : shift left one place, i_sin enters at bit 0
//   o_q, o_sout    : parallel contents, serial out (MSB)
module seq_shift_reg
  import conway_pkg::*;
#(
  parameter int WIDTH = DATA_SIZE_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     r_q <= '0;
    else if (i_load)  r_q <= i_load_val;
    else if (i_shift) r_q <= {r_q[WIDTH-2:0], i_sin};
  end

  assign o_q    = r_q;
  assign o_sout = r_q[WIDTH-1];

endmodule

// File: rtl/conway_serial_sequencer.sv
// Drives one job through the serial Conway core: shift seed in (LOAD),
// run N generations (RUN), shift result out (READ), pulse DONE.
//   CLK, RESET : clock, synchronous active-low reset
//   sif        : START/GRID_LOAD/GEN_COUNT request, DATA_OUT/MODE to core,
//                DATA_IN from core, BUSY/DONE/GRID_RESULT status
module conway_serial_sequencer
  import conway_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int GEN_WIDTH = GEN_WIDTH_DEF
) (
  input logic CLK,
  input logic RESET,
  conway_serial_sequencer_if.slave sif
);

  localparam int             CW       = $clog2(DATA_SIZE + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_SIZE - 1);

  seq_state_t           r_state, w_next;
  logic [CW-1:0]        r_bit_cnt;
  logic [GEN_WIDTH-1:0] r_gen_cnt;
  logic [1:0]           r_mode;
  logic                 r_busy;
  logic                 r_done;
  logic [DATA_SIZE-1:0] r_result;

  logic                 w_accept;
  logic                 w_bit_last;
  logic                 w_gen_last;
  logic                 w_load_sout;
  logic [DATA_SIZE-1:0] w_unused_load_q;
  logic [DATA_SIZE-1:0] w_cap_q;
  logic                 w_unused_cap_sout;

  assign w_accept   = (r_state == IDLE) && sif.START;
  assign w_bit_last = (r_bit_cnt == LAST_BIT);
  // RUN is only entered with a nonzero count; <=1 also covers a stray 0.
  assign w_gen_last = (r_gen_cnt <= GEN_WIDTH'(1));

  // Seed register: MSB goes out first, zeros shift in so DATA_OUT idles low
  // once the seed has been sent.
  seq_shift_reg #(.WIDTH(DATA_SIZE)) u_load_sh (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_load     (w_accept),
    .i_load_val (sif.GRID_LOAD),
    .i_shift    (r_state == LOAD),
    .i_sin      (1'b0),
    .o_q        (w_unused_load_q),
    .o_sout     (w_load_sout)
  );

  // Capture register: core memory arrives MSB first.
  seq_shift_reg #(.WIDTH(DATA_SIZE)) u_cap_sh (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_shift    (r_state == READ),
    .i_sin      (sif.DATA_IN),
    .o_q        (w_cap_q),
    .o_sout     (w_unused_cap_sout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (sif.START) w_next = LOAD;
      LOAD: if (w_bit_last) w_next = (r_gen_cnt != '0) ? RUN : READ;
      RUN:  if (w_gen_last) w_next = READ;
      READ: if (w_bit_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State plus registered outputs decoded from the next state, so MODE/BUSY/DONE
  // line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_mode  <= MODE_STOP;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mode  <= mode_of(w_next);
      r_busy  <= (w_next == LOAD) || (w_next == RUN) || (w_next == READ);
      r_done  <= (w_next == DONE);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_bit_cnt <= '0;
      r_gen_cnt <= '0;
      r_result  <= '0;
    end else begin
      // One counter serves both LOAD and READ; it is back at 0 between them.
      if (r_state == LOAD || r_state == READ)
        r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + CW'(1);

      if (w_accept)
        r_gen_cnt <= sif.GEN_COUNT;
      else if (r_state == RUN && r_gen_cnt != '0)
        r_gen_cnt <= r_gen_cnt - GEN_WIDTH'(1);

      // Include the bit being captured on this final edge.
      if (r_state == READ && w_bit_last)
        r_result <= {w_cap_q[DATA_SIZE-2:0], sif.DATA_IN};
    end
  end

  assign sif.DATA_OUT    = w_load_sout;
  assign sif.MODE        = r_mode;
  assign sif.BUSY        = r_busy;
  assign sif.DONE        = r_done;
  assign sif.GRID_RESULT = r_result;

endmodule

// File: tb/tb_conway_serial_sequencer.sv
`timescale 1ns/1ps
module tb_conway_serial_sequencer;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_0038_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0000_1010_1000;
  localparam logic [63:0] CORNERS = 64'h8000_0000_0000_0001;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  conway_serial_sequencer_if #(.DATA_SIZE(64), .GEN_WIDTH(16)) b0();
  conway_serial_sequencer_if #(.DATA_SIZE(64), .GEN_WIDTH(4))  b1();

  conway_serial_sequencer #(.DATA_SIZE(64), .GEN_WIDTH(16)) dut0 (
    .CLK(CLK), .RESET(RESET), .sif(b0));
  conway_serial_sequencer #(.DATA_SIZE(64), .GEN_WIDTH(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .sif(b1));

  // Behavioural 8x8 core, dead cells beyond the border.
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                c + dc >= 0 && c + dc < 8)
              cnt += int'(g[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = (cnt == 3) || (cnt == 2 && g[r * 8 + c]);
      end
    return n;
  endfunction

  logic [63:0] mem0 = '0;
  logic [63:0] mem1 = '0;
  assign b0.DATA_IN = mem0[63];
  assign b1.DATA_IN = mem1[63];

  always @(posedge CLK) begin
    case (b0.MODE)
      2'b00:   mem0 <= {mem0[62:0], b0.DATA_OUT};
      2'b01:   mem0 <= life(mem0);
      2'b10:   mem0 <= {mem0[62:0], 1'b0};
      default: ;
    endcase
  end

  always @(posedge CLK) begin
    case (b1.MODE)
      2'b00:   mem1 <= {mem1[62:0], b1.DATA_OUT};
      2'b01:   mem1 <= life(mem1);
      2'b10:   mem1 <= {mem1[62:0], 1'b0};
      default: ;
    endcase
  end

  int checks = 0, passes = 0, fails = 0;
  int lat, n_ld, n_rn, n_rd, n_dout_run;
  logic [63:0] dtr;
  logic seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic done_now(input int sel);
    return (sel != 0) ? b1.DONE : b0.DONE;
  endfunction

  // Issue one job and follow it to DONE. lat counts samples after the START
  // edge; DONE is first seen at lat = 2*64 + G, i.e. in the cycle that closes
  // at edge k + 2*64 + G + 1. poke=1 pulses START in LOAD, RUN and READ.
  task automatic job(input int sel, input logic [63:0] g, input logic [15:0] n, input int poke);
    logic [1:0] m;
    logic dout;
    if (sel != 0) begin b1.GRID_LOAD = g; b1.GEN_COUNT = n[3:0]; b1.START = 1'b1; end
    else          begin b0.GRID_LOAD = g; b0.GEN_COUNT = n;      b0.START = 1'b1; end
    tick();
    b0.START = 1'b0; b1.START = 1'b0;
    b0.GRID_LOAD = ~g; b1.GRID_LOAD = ~g;   // free to change after acceptance
    lat = 0; n_ld = 0; n_rn = 0; n_rd = 0; n_dout_run = 0; dtr = '0;
    while (!done_now(sel) && lat < 400) begin
      m    = (sel != 0) ? b1.MODE : b0.MODE;
      dout = (sel != 0) ? b1.DATA_OUT : b0.DATA_OUT;
      case (m)
        2'b00: begin n_ld++; dtr = {dtr[62:0], dout}; end
        2'b01: begin n_rn++; if (dout) n_dout_run++; end
        2'b10: n_rd++;
        default: ;
      endcase
      if (poke != 0) b0.START = (lat == 10 || lat == 65 || lat == 100);
      tick();
      lat++;
    end
    b0.START = 1'b0;
    chk("done_seen", 64'(done_now(sel)), 64'd1);
  endtask

  initial begin
    b0.START = 1'b0; b0.GRID_LOAD = '0; b0.GEN_COUNT = '0;
    b1.START = 1'b0; b1.GRID_LOAD = '0; b1.GEN_COUNT = '0;

    // 1. reset in the middle of random activity
    tick(); tick();
    RESET = 1'b1;
    b0.GRID_LOAD = {$urandom, $urandom}; b0.GEN_COUNT = 16'd7; b0.START = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      b0.START = 1'($urandom_range(0, 1));
      b0.GRID_LOAD = {$urandom, $urandom};
    end
    RESET = 1'b0;
    tick(); tick();
    chk("rst_mode",   64'(b0.MODE), 64'd3);
    chk("rst_dout",   64'(b0.DATA_OUT), 64'd0);
    chk("rst_busy",   64'(b0.BUSY), 64'd0);
    chk("rst_done",   64'(b0.DONE), 64'd0);
    chk("rst_result", b0.GRID_RESULT, 64'd0);
    chk("rst_mode1",  64'(b1.MODE), 64'd3);
    b0.START = 1'b0;
    RESET = 1'b1;
    tick();

    // 2. bit order, no run phase
    job(0, CORNERS, 16'd0, 0);
    chk("bo_latency", 64'(lat), 64'd128);
    chk("bo_load_cy", 64'(n_ld), 64'd64);
    chk("bo_run_cy",  64'(n_rn), 64'd0);
    chk("bo_read_cy", 64'(n_rd), 64'd64);
    chk("bo_dout_seq", dtr, CORNERS);
    chk("bo_result", b0.GRID_RESULT, CORNERS);
    chk("bo_done_mode", 64'(b0.MODE), 64'd3);
    chk("bo_done_busy", 64'(b0.BUSY), 64'd0);
    tick();
    chk("bo_done_pulse", 64'(b0.DONE), 64'd0);
    chk("bo_result_hold", b0.GRID_RESULT, CORNERS);

    // 3. blinker, odd and even generation counts
    job(0, BLINK_H, 16'd3, 0);
    chk("bl3_run_cy", 64'(n_rn), 64'd3);
    chk("bl3_dout_run", 64'(n_dout_run), 64'd0);
    chk("bl3_latency", 64'(lat), 64'd131);
    chk("bl3_result", b0.GRID_RESULT, BLINK_V);
    tick();
    job(0, BLINK_H, 16'd2, 0);
    chk("bl2_run_cy", 64'(n_rn), 64'd2);
    chk("bl2_result", b0.GRID_RESULT, BLINK_H);
    tick();

    // 4a. START pulses while busy are ignored
    job(0, BLINK_H, 16'd3, 1);
    chk("busy_latency", 64'(lat), 64'd131);
    chk("busy_load_cy", 64'(n_ld), 64'd64);
    chk("busy_result", b0.GRID_RESULT, BLINK_V);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b0.DONE || b0.BUSY) seen = 1'b1;
    end
    chk("busy_no_restart", 64'(seen), 64'd0);

    // 4b. START held high: back-to-back jobs with one IDLE cycle between
    b0.GRID_LOAD = BLINK_H; b0.GEN_COUNT = 16'd1; b0.START = 1'b1;
    tick();
    lat = 0;
    while (!b0.DONE && lat < 400) begin tick(); lat++; end
    chk("hold_lat1", 64'(lat), 64'd129);
    tick();
    chk("hold_idle_mode", 64'(b0.MODE), 64'd3);
    chk("hold_idle_busy", 64'(b0.BUSY), 64'd0);
    chk("hold_idle_done", 64'(b0.DONE), 64'd0);
    tick();
    chk("hold_reload", 64'(b0.MODE), 64'd0);
    lat = 0;
    while (!b0.DONE && lat < 400) begin tick(); lat++; end
    chk("hold_lat2", 64'(lat), 64'd129);
    chk("hold_result", b0.GRID_RESULT, BLINK_V);
    b0.START = 1'b0;
    tick(); tick();
    chk("hold_stop", 64'(b0.MODE), 64'd3);

    // 5. abort in RUN cycle 2
    b0.GRID_LOAD = BLINK_H; b0.GEN_COUNT = 16'd5; b0.START = 1'b1;
    tick();
    b0.START = 1'b0;
    for (int i = 0; i < 65; i++) tick();
    chk("abort_in_run", 64'(b0.MODE), 64'd1);
    RESET = 1'b0;
    tick();
    chk("abort_mode",   64'(b0.MODE), 64'd3);
    chk("abort_busy",   64'(b0.BUSY), 64'd0);
    chk("abort_result", b0.GRID_RESULT, 64'd0);
    RESET = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b0.DONE) seen = 1'b1;
      tick();
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    job(0, BLINK_H, 16'd5, 0);
    chk("abort_rerun_run_cy", 64'(n_rn), 64'd5);
    chk("abort_rerun_result", b0.GRID_RESULT, BLINK_V);
    tick();

    // 6. 4-bit generation counter at full scale
    job(1, BLINK_H, 16'h000F, 0);
    chk("g4_run_cy",  64'(n_rn), 64'd15);
    chk("g4_latency", 64'(lat), 64'd143);
    chk("g4_result",  b1.GRID_RESULT, BLINK_V);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
